// File: rtl/game_pkg.sv
// Shared definitions for the paddle/ball game sequencer.
// State codes are fixed so the debug/display state port keeps a stable encoding.
package game_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOSE  = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Button/collision inputs and mover/display outputs of the game sequencer.
//   master : environment side (drives buttons and collision sources)
//   slave  : sequencer side (drives mover enables, strobes, lives and state)
interface game_sequencer_if #(
    parameter int unsigned LIVES_W = 2
);
    logic                        pb1;
    logic                        pb2;
    logic                        collision;
    logic                        paddlegone;
    logic                        move_carpet;
    logic                        move_ball;
    logic                        move_paddle;
    logic                        load_random;
    logic                        dec_lives;
    logic                        load_lives;
    logic                        paddle_hide;
    logic [LIVES_W-1:0]          lives;
    logic [game_pkg::STATE_W-1:0] state;

    modport master (
        output pb1, pb2, collision, paddlegone,
        input  move_carpet, move_ball, move_paddle, load_random, dec_lives,
               load_lives, paddle_hide, lives, state
    );

    modport slave (
        input  pb1, pb2, collision, paddlegone,
        output move_carpet, move_ball, move_paddle, load_random, dec_lives,
               load_lives, paddle_hide, lives, state
    );
endinterface

// File: rtl/sec_timer.sv
// Seconds timer: prescaler 0..TICK_DIV-1 feeding a seconds counter that
// saturates at SECS_MAX.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : synchronous clear (wins over enable)
//   i_enable   : count this cycle
//   o_secs     : whole seconds elapsed
//   o_last_c   : this enabled cycle completes second SECS_MAX
module sec_timer #(
    parameter  int unsigned TICK_DIV = 50_000_000,
    parameter  int unsigned SECS_MAX = 4,
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
    localparam int unsigned SEC_W    = $clog2(SECS_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [SEC_W-1:0] o_secs,
    output logic             o_last_c
);

    logic [PRE_W-1:0] r_pre;
    logic [SEC_W-1:0] r_secs;
    logic             w_sat;
    logic             w_wrap;

    assign w_sat  = (r_secs == SEC_W'(SECS_MAX));
    assign w_wrap = (r_pre == PRE_W'(TICK_DIV - 1));

    // Prescaler and seconds counter; frozen once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_secs <= '0;
        end else if (i_clear) begin
            r_pre  <= '0;
            r_secs <= '0;
        end else if (i_enable && !w_sat) begin
            if (w_wrap) begin
                r_pre  <= '0;
                r_secs <= r_secs + SEC_W'(1);
            end else begin
                r_pre  <= r_pre + PRE_W'(1);
            end
        end
    end

    assign o_secs   = r_secs;
    assign o_last_c = i_enable && !w_sat && w_wrap && (r_secs == SEC_W'(SECS_MAX - 1));

endmodule

// File: rtl/game_sequencer.sv
// Registered top-level sequencer for the paddle/ball game: state register,
// serve timer, lives counter and button edge detection, decoding mover
// enables and strobes from the current state.
//   clk, rst_n : clock, async active-low reset
//   bus        : game_sequencer_if.slave (pb1, pb2, collision, paddlegone in;
//                move_*, load_random, dec_lives, load_lives, paddle_hide,
//                lives, state out)
// Optional feature: define GAME_PAUSE_EN to add the PAUSE state (pb2 toggles
// pause from PLAY, pb1 in PAUSE aborts to OVER). Otherwise pb2 is ignored.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned SERVE_SECS = 4,
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned LIVES_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    game_sequencer_if.slave      bus
);

    localparam int unsigned SEC_W = $clog2(SERVE_SECS + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_entry;
    logic [LIVES_W-1:0] r_lives;
    logic               r_pb1_d;
    logic               w_pb1_rise;
    logic               w_pb2_rise;
    logic               w_loss;
    logic [SEC_W-1:0]   w_secs;
    logic               w_sec_last_c;

    // Button edge detection: a held button acts only once.
`ifdef GAME_PAUSE_EN
    logic r_pb2_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pb2_d <= 1'b0;
        else        r_pb2_d <= bus.pb2;
    end
    assign w_pb2_rise = bus.pb2 && !r_pb2_d;
`else
    logic w_pb2_unused;
    assign w_pb2_unused = bus.pb2;
    assign w_pb2_rise   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pb1_d <= 1'b0;
        else        r_pb1_d <= bus.pb1;
    end
    assign w_pb1_rise = bus.pb1 && !r_pb1_d;

    // Simultaneous collision and paddle loss count as a single loss.
    assign w_loss = bus.collision || bus.paddlegone;

    // Serve timer: cleared on every state change, counts only while serving.
    sec_timer #(
        .TICK_DIV (TICK_DIV),
        .SECS_MAX (SERVE_SECS)
    ) u_sec_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_state_next != r_state),
        .i_enable (r_state == ST_SERVE),
        .o_secs   (w_secs),
        .o_last_c (w_sec_last_c)
    );

    // State register plus first-cycle-of-state flag for entry strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_entry <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_entry <= (w_state_next != r_state);
        end
    end

    // Lives: reloaded throughout IDLE, decremented (saturating) in LOSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lives <= LIVES_W'(LIVES_INIT);
        end else if (r_state == ST_IDLE) begin
            r_lives <= LIVES_W'(LIVES_INIT);
        end else if ((r_state == ST_LOSE) && (r_lives != '0)) begin
            r_lives <= r_lives - LIVES_W'(1);
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        w_state_next    = r_state;
        bus.move_carpet = 1'b0;
        bus.move_ball   = 1'b0;
        bus.move_paddle = 1'b0;
        bus.load_random = 1'b0;
        bus.dec_lives   = 1'b0;
        bus.load_lives  = 1'b0;
        bus.paddle_hide = 1'b0;

        case (r_state)
            ST_IDLE: begin
                bus.load_lives  = 1'b1;
                bus.paddle_hide = 1'b1;
                if (w_pb1_rise) w_state_next = ST_SERVE;
            end
            ST_SERVE: begin
                bus.load_random = r_entry;
                bus.move_paddle = 1'b1;
                bus.move_carpet = 1'b1;
                // Saturated-count check is a guard; normal release is on the last tick.
                if (w_sec_last_c || (w_secs == SEC_W'(SERVE_SECS))) w_state_next = ST_PLAY;
            end
            ST_PLAY: begin
                bus.move_ball   = 1'b1;
                bus.move_paddle = 1'b1;
                bus.move_carpet = 1'b1;
                bus.paddle_hide = bus.paddlegone;
                if (w_loss)          w_state_next = ST_LOSE;
                else if (w_pb2_rise) w_state_next = ST_PAUSE;
            end
            ST_LOSE: begin
                bus.dec_lives = 1'b1;
                if (r_lives <= LIVES_W'(1)) w_state_next = ST_OVER;
                else                        w_state_next = ST_SERVE;
            end
            ST_OVER: begin
                bus.paddle_hide = 1'b1;
                if (w_pb1_rise) w_state_next = ST_IDLE;
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                if (w_pb1_rise)      w_state_next = ST_OVER;
                else if (w_pb2_rise) w_state_next = ST_PLAY;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.lives = r_lives;
    assign bus.state = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios followed by
// randomized button/collision traffic, compared each cycle against a
// cycle-count reference model of the game rules.
module tb_game_sequencer;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned SERVE_SECS = 4;
    localparam int unsigned LIVES_INIT = 3;
    localparam int unsigned LIVES_W    = 2;
    localparam int          SERVE_CYC  = SERVE_SECS * TICK_DIV;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    game_sequencer_if #(.LIVES_W(LIVES_W)) bus ();

    game_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .SERVE_SECS (SERVE_SECS),
        .LIVES_INIT (LIVES_INIT),
        .LIVES_W    (LIVES_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: game state as a plain integer, serve time as a cycle count.
    int m_state;
    int m_lives;
    int m_serve_cnt;
    bit m_first;
    bit m_p1;
    bit m_p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state     = 0;
        m_lives     = LIVES_INIT;
        m_serve_cnt = 0;
        m_first     = 1'b1;
        m_p1        = 1'b0;
        m_p2        = 1'b0;
    endtask

    // Apply one clock edge of game rules using the inputs held over that edge.
    task automatic model_update();
        bit e1;
        bit e2;
        int nxt;
        e1   = bus.pb1 && !m_p1;
        e2   = bus.pb2 && !m_p2;
        m_p1 = bus.pb1;
        m_p2 = bus.pb2;
        nxt  = m_state;
        case (m_state)
            0: begin
                m_lives = LIVES_INIT;
                if (e1) nxt = 1;
            end
            1: begin
                m_serve_cnt++;
                if (m_serve_cnt >= SERVE_CYC) nxt = 2;
            end
            2: begin
                if (bus.collision || bus.paddlegone) nxt = 3;
                else if (PAUSE_EN && e2)             nxt = 5;
            end
            3: begin
                nxt = (m_lives == 1) ? 4 : 1;
                if (m_lives > 0) m_lives--;
            end
            4: if (e1) nxt = 0;
            5: begin
                if (e1)      nxt = 4;
                else if (e2) nxt = 2;
            end
            default: nxt = 0;
        endcase
        m_first = (nxt != m_state);
        if (m_first) m_serve_cnt = 0;
        m_state = nxt;
    endtask

    task automatic check_all(input string tag);
        bit e_hide;
        e_hide = (m_state == 0) || (m_state == 4) || ((m_state == 2) && bus.paddlegone);
        chk({tag, ".state"},       32'(bus.state),       32'(m_state));
        chk({tag, ".lives"},       32'(bus.lives),       32'(m_lives));
        chk({tag, ".move_ball"},   32'(bus.move_ball),   32'(m_state == 2));
        chk({tag, ".move_paddle"}, 32'(bus.move_paddle), 32'((m_state == 1) || (m_state == 2)));
        chk({tag, ".move_carpet"}, 32'(bus.move_carpet), 32'((m_state == 1) || (m_state == 2)));
        chk({tag, ".load_random"}, 32'(bus.load_random), 32'((m_state == 1) && m_first));
        chk({tag, ".dec_lives"},   32'(bus.dec_lives),   32'(m_state == 3));
        chk({tag, ".load_lives"},  32'(bus.load_lives),  32'(m_state == 0));
        chk({tag, ".paddle_hide"}, 32'(bus.paddle_hide), 32'(e_hide));
    endtask

    // One clock: model follows the edge, outputs checked at the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while ((32'(bus.state) != 32'(target)) && (n < budget)) begin
            step(tag);
            n++;
        end
        chk({tag, ".reached"}, 32'(bus.state), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int play_at;
        int n_lr;
        int n_dec;

        rst_n          = 1'b0;
        bus.pb1        = 1'b0;
        bus.pb2        = 1'b0;
        bus.collision  = 1'b0;
        bus.paddlegone = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Idle after reset.
        repeat (10) step("idle");
        chk("idle.state",      32'(bus.state),      32'(0));
        chk("idle.lives",      32'(bus.lives),      32'(LIVES_INIT));
        chk("idle.load_lives", 32'(bus.load_lives), 32'(1));

        // pb1 held 20 cycles: single serve, one load_random, PLAY after 16 serve cycles.
        bus.pb1 = 1'b1;
        play_at = -1;
        n_lr    = 0;
        for (int i = 1; i <= 20; i++) begin
            step("serve");
            if (bus.load_random) n_lr++;
            if ((play_at < 0) && (bus.state == 3'd2)) play_at = i;
        end
        bus.pb1 = 1'b0;
        chk("serve.load_random_cycles", 32'(n_lr),    32'(1));
        chk("serve.play_at_cycle",      32'(play_at), 32'(SERVE_CYC + 1));

        // Simultaneous collision + paddlegone: one loss.
        bus.collision  = 1'b1;
        bus.paddlegone = 1'b1;
        step("loss1");
        n_dec = bus.dec_lives ? 1 : 0;
        bus.collision  = 1'b0;
        bus.paddlegone = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("loss1_after");
            if (bus.dec_lives) n_dec++;
        end
        chk("loss1.dec_pulses", 32'(n_dec),     32'(1));
        chk("loss1.lives",      32'(bus.lives), 32'(2));
        chk("loss1.state",      32'(bus.state), 32'(1));

        // Pause toggle from PLAY.
        run_until("to_play2", 2, 40);
        bus.pb2 = 1'b1;
        step("pause_on");
        chk("pause_on.state", 32'(bus.state), PAUSE_EN ? 32'(5) : 32'(2));
        step("pause_held");
        bus.pb2 = 1'b0;
        step("pause_rel");
        bus.pb2 = 1'b1;
        step("pause_off");
        chk("pause_off.state", 32'(bus.state), 32'(2));
        bus.pb2 = 1'b0;
        step("pause_done");

        // Second and third losses -> OVER.
        bus.collision = 1'b1;
        step("loss2");
        bus.collision = 1'b0;
        step("loss2_after");
        chk("loss2.lives", 32'(bus.lives), 32'(1));
        run_until("to_play3", 2, 40);
        bus.paddlegone = 1'b1;
        #1;
        chk("play.hide_follows_pg", 32'(bus.paddle_hide), 32'(1));
        step("loss3");
        bus.paddlegone = 1'b0;
        step("loss3_after");
        chk("over.state", 32'(bus.state),       32'(4));
        chk("over.lives", 32'(bus.lives),       32'(0));
        chk("over.hide",  32'(bus.paddle_hide), 32'(1));

        // pb1 from OVER -> IDLE, lives reload.
        bus.pb1 = 1'b1;
        step("restart");
        bus.pb1 = 1'b0;
        step("restart_idle");
        step("restart_idle");
        chk("restart.state", 32'(bus.state), 32'(0));
        chk("restart.lives", 32'(bus.lives), 32'(LIVES_INIT));

        // Async reset in the middle of SERVE, checked before the next rising edge.
        bus.pb1 = 1'b1;
        step("rst_serve");
        bus.pb1 = 1'b0;
        repeat (5) step("rst_serve");
        chk("rst_pre.state", 32'(bus.state), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.state", 32'(bus.state), 32'(0));
        chk("async_rst.lives", 32'(bus.lives), 32'(LIVES_INIT));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bus.pb1        = ($urandom_range(0, 3) == 0);
            bus.pb2        = ($urandom_range(0, 3) == 0);
            bus.collision  = ($urandom_range(0, 29) == 0);
            bus.paddlegone = ($urandom_range(0, 39) == 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
